// File: rtl/key_input_array.sv
// Multi-channel button front end: 2-flop sync, shared sample tick, per-channel debounce, press/release pulses.
// Latency: 2 clk sync + wait to next tick + (STABLE_SAMPLES-1) ticks + 1 clk register; no backpressure, pulses are fire-and-forget.
// Optional auto-repeat on held buttons when KEY_AUTOREPEAT_EN is defined.
module key_input_array #(
    parameter int CHANNELS       = 5,
    parameter int CLK_HZ         = 100000000,
    parameter int SAMPLE_HZ      = 1000,
    parameter int STABLE_SAMPLES = 8,
    parameter int REPEAT_DELAY   = 400,
    parameter int REPEAT_PERIOD  = 100
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] btn_press,
    output logic [CHANNELS-1:0] btn_release,
    output logic                sample_tick
);

    localparam int            DIV      = CLK_HZ / SAMPLE_HZ;
    localparam int            PW       = $clog2(DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam int            CW       = $clog2(STABLE_SAMPLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_SAMPLES - 1);

`ifdef KEY_AUTOREPEAT_EN
    localparam int            RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int            RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] RDLY = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RPER = RW'(REPEAT_PERIOD);

    typedef enum logic {
        WAIT_DELAY,
        REPEATING
    } rep_state_t;
`else
    localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD;
`endif

    logic [CHANNELS-1:0] sync1;
    logic [CHANNELS-1:0] sync2;
    logic [PW-1:0]       pre_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (pre_cnt == PRE_LAST) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

    assign sample_tick = (pre_cnt == PRE_LAST);

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic [CW-1:0] db_cnt;
        logic          level_q;
        logic          press_q;
        logic          release_q;
        logic          differ;
        logic          flip;
        logic          rep_pulse;

        assign differ = sync2[ch] ^ level_q;
        // Level flips on the tick that completes a run of differing samples.
        assign flip   = sample_tick & differ & (db_cnt == CNT_LAST);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                db_cnt    <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                press_q   <= (flip & ~level_q) | rep_pulse;
                release_q <= flip & level_q;
                if (flip) begin
                    level_q <= ~level_q;
                end
                if (sample_tick) begin
                    if (!differ || flip) begin
                        db_cnt <= '0;
                    end else begin
                        db_cnt <= db_cnt + CW'(1);
                    end
                end
            end
        end

`ifdef KEY_AUTOREPEAT_EN
        rep_state_t    state_q;
        rep_state_t    state_d;
        logic [RW-1:0] rcnt_q;
        logic [RW-1:0] rcnt_d;
        logic [RW-1:0] rcnt_inc;

        assign rcnt_inc = rcnt_q + RW'(1);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= WAIT_DELAY;
                rcnt_q  <= '0;
            end else begin
                state_q <= state_d;
                rcnt_q  <= rcnt_d;
            end
        end

        always_comb begin
            state_d   = state_q;
            rcnt_d    = rcnt_q;
            rep_pulse = 1'b0;
            if (!level_q || flip) begin
                // Idle, the press tick itself, or the release tick: park at the start of the delay.
                state_d = WAIT_DELAY;
                rcnt_d  = '0;
            end else if (sample_tick) begin
                case (state_q)
                    WAIT_DELAY: begin
                        if (rcnt_inc == RDLY) begin
                            rep_pulse = 1'b1;
                            state_d   = REPEATING;
                            rcnt_d    = '0;
                        end else begin
                            rcnt_d = rcnt_inc;
                        end
                    end
                    REPEATING: begin
                        if (rcnt_inc == RPER) begin
                            rep_pulse = 1'b1;
                            rcnt_d    = '0;
                        end else begin
                            rcnt_d = rcnt_inc;
                        end
                    end
                endcase
            end
        end
`else
        assign rep_pulse = 1'b0;
`endif

        assign btn_level[ch]   = level_q;
        assign btn_press[ch]   = press_q;
        assign btn_release[ch] = release_q;
    end

endmodule

// File: tb/tb_key_input_array.sv
// Directed bench for key_input_array with a 10-cycle sample tick and 4-sample debounce.
module tb_key_input_array;

`ifdef KEY_AUTOREPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif
    localparam logic [4:0] REP_EXP = REP_ON ? 5'b00001 : 5'b00000;

    logic       clk;
    logic       rst_n;
    logic [4:0] btn_in;
    logic [4:0] btn_level;
    logic [4:0] btn_press;
    logic [4:0] btn_release;
    logic       sample_tick;

    int         vectors;
    int         errs;
    int         cycle;
    int         press_cnt [5];
    int         rel_cnt   [5];
    int         press_cycles;
    logic [4:0] lvl_or;

    key_input_array #(
        .CHANNELS      (5),
        .CLK_HZ        (1000),
        .SAMPLE_HZ     (100),
        .STABLE_SAMPLES(4),
        .REPEAT_DELAY  (5),
        .REPEAT_PERIOD (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .sample_tick(sample_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_cnt();
        for (int i = 0; i < 5; i++) begin
            press_cnt[i] = 0;
            rel_cnt[i]   = 0;
        end
        press_cycles = 0;
        lvl_or       = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        cycle++;
        for (int i = 0; i < 5; i++) begin
            press_cnt[i] += int'(btn_press[i]);
            rel_cnt[i]   += int'(btn_release[i]);
        end
        if (btn_press != '0) press_cycles++;
        lvl_or |= btn_level;
    endtask

    task automatic run_to(input int c);
        while (cycle < c) cyc();
    endtask

    function automatic logic [4:0] once_vec();
        logic [4:0] v;
        for (int i = 0; i < 5; i++) v[i] = (press_cnt[i] == 1);
        return v;
    endfunction

    initial begin
        vectors = 0;
        errs    = 0;
        cycle   = 0;
        clear_cnt();
        rst_n  = 1'b0;
        btn_in = 5'b11111;

        // Reset with all buttons held
        repeat (5) cyc();
        check("rst_level", btn_level, 5'b00000);
        check("rst_press", btn_press, 5'b00000);
        check("rst_release", btn_release, 5'b00000);
        check("rst_tick", sample_tick, 1'b0);

        rst_n = 1'b1;
        cycle = 0;
        clear_cnt();
        run_to(8);
        check("tick_before_term", sample_tick, 1'b0);
        run_to(9);
        check("tick_at_term", sample_tick, 1'b1);
        run_to(39);
        check("rst_level_pre", btn_level, 5'b00000);
        run_to(40);
        check("rst_level_up", btn_level, 5'b11111);
        check("rst_press_pulse", btn_press, 5'b11111);
        run_to(43);
        check("rst_press_once", once_vec(), 5'b11111);
        check("rst_press_cycles", press_cycles, 1);

        // Release of channel 1
        run_to(45);
        btn_in = 5'b11101;
        run_to(79);
        check("rel_level_pre", btn_level, 5'b11111);
        run_to(80);
        check("rel_level", btn_level, 5'b11101);
        check("rel_pulse", btn_release, 5'b00010);
        check("rel_no_press", btn_press, 5'b00000);
        run_to(81);
        check("rel_pulse_end", btn_release, 5'b00000);
        check("rel_count", rel_cnt[1], 1);

        run_to(85);
        btn_in = 5'b00000;
        run_to(120);
        check("all_rel_level", btn_level, 5'b00000);
        check("all_rel_pulse", btn_release, 5'b11101);

        // Bounce on channel 0: toggle every 3 cycles for 60 cycles, then hold
        clear_cnt();
        run_to(125);
        for (int k = 0; k < 20; k++) begin
            btn_in[0] = (k % 2 == 0);
            repeat (3) cyc();
        end
        btn_in[0] = 1'b1;
        check("bounce_no_press", press_cnt[0], 0);
        run_to(219);
        check("bounce_settle_pre", press_cnt[0], 0);
        run_to(220);
        check("bounce_press", btn_press, 5'b00001);
        check("bounce_level", btn_level, 5'b00001);
        run_to(222);
        check("bounce_press_once", press_cnt[0], 1);
        btn_in[0] = 1'b0;

        // Glitch on channel 2 across three ticks
        clear_cnt();
        run_to(225);
        btn_in[2] = 1'b1;
        run_to(250);
        btn_in[2] = 1'b0;
        run_to(260);
        check("ch0_release_level", btn_level, 5'b00000);
        check("ch0_release_pulse", btn_release, 5'b00001);
        run_to(280);
        check("glitch_level", lvl_or[2], 1'b0);
        check("glitch_press", press_cnt[2], 0);
        check("glitch_release", rel_cnt[2], 0);

        // Simultaneous press on channels 3 and 4
        clear_cnt();
        run_to(285);
        btn_in = 5'b11000;
        run_to(319);
        check("simul_pre", btn_press, 5'b00000);
        run_to(320);
        check("simul_press", btn_press, 5'b11000);
        check("simul_level", btn_level, 5'b11000);
        run_to(325);
        check("simul_single_cycle", press_cycles, 1);
        btn_in = 5'b00000;
        run_to(360);
        check("simul_release", btn_release, 5'b11000);

        // Long hold on channel 0: repeats only with auto-repeat built in
        clear_cnt();
        run_to(365);
        btn_in[0] = 1'b1;
        run_to(400);
        check("hold_press", btn_press, 5'b00001);
        run_to(449);
        check("hold_449", btn_press, 5'b00000);
        run_to(450);
        check("hold_rep_450", btn_press, REP_EXP);
        run_to(470);
        check("hold_rep_470", btn_press, REP_EXP);
        run_to(490);
        check("hold_rep_490", btn_press, REP_EXP);
        run_to(495);
        btn_in[0] = 1'b0;
        run_to(510);
        check("hold_rep_510", btn_press, REP_EXP);
        run_to(530);
        check("hold_rel_level", btn_level, 5'b00000);
        check("hold_rel_pulse", btn_release, 5'b00001);
        check("hold_no_trailing", btn_press, 5'b00000);
        run_to(560);
        check("hold_press_total", press_cnt[0], REP_ON ? 5 : 1);

        // Reset while channel 4 is held
        btn_in = 5'b10000;
        run_to(600);
        check("midrst_level_pre", btn_level, 5'b10000);
        run_to(605);
        rst_n = 1'b0;
        #1;
        check("midrst_async_level", btn_level, 5'b00000);
        repeat (3) cyc();
        check("midrst_held_press", btn_press, 5'b00000);
        rst_n = 1'b1;
        cycle = 0;
        clear_cnt();
        run_to(39);
        check("midrst_level_wait", btn_level, 5'b00000);
        run_to(40);
        check("midrst_fresh_level", btn_level, 5'b10000);
        check("midrst_fresh_press", btn_press, 5'b10000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
